// File: rtl/wb_tpm_bridge.sv
// rtl/wb_tpm_bridge.sv - Wishbone client for TPM buffer RAM port B and exec/abort/complete control (optional TWPM_WB_BUF_PROTECT_EN)
module wb_tpm_bridge #(
  parameter int RAM_AW      = 9,
  parameter bit IRQ_DEFAULT = 1'b0
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [16:0]       wb_adr_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wd_o,
  output logic [3:0]        ram_wen_o,
  output logic              ram_wr_o,
  output logic              ram_rd_o,
  input  logic [31:0]       ram_rd_i,
  input  logic              exec_i,
  input  logic              abort_i,
  output logic              complete_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        exec_q, abort_q;
  logic        exec_pend_q, exec_pend_d;
  logic        abort_pend_q, abort_pend_d;
  logic        complete_q, complete_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic        wr_denied;

  logic        req, sel_buf, sel_status, sel_ctrl, sel_irqen;
  logic        buf_rd, buf_wr_req, buf_wr_ok, ctrl_wr, irqen_wr;
  logic        exec_rise, abort_rise;
  logic [31:0] reg_rdata;
  logic        unused_adr;

  // Only a strobe seen in IDLE starts a transfer; reset gates it so RAM enables drop at once.
  assign req        = (state_q == ST_IDLE) & wb_cyc_i & wb_stb_i & nrst_i;
  assign sel_buf    = (wb_adr_i[16:11] == 6'd0);
  assign sel_status = (wb_adr_i[16:2] == 15'h0400);
  assign sel_ctrl   = (wb_adr_i[16:2] == 15'h0401);
  assign sel_irqen  = (wb_adr_i[16:2] == 15'h0402);
  assign unused_adr = ^wb_adr_i[1:0];

  assign buf_rd     = req & ~wb_we_i & sel_buf;
  assign buf_wr_req = req & wb_we_i & sel_buf;
  assign ctrl_wr    = req & wb_we_i & sel_ctrl;
  assign irqen_wr   = req & wb_we_i & sel_irqen;

`ifdef TWPM_WB_BUF_PROTECT_EN
  logic wr_denied_q;

  // Firmware may only touch the buffer while a command is pending; other writes are dropped.
  assign buf_wr_ok = buf_wr_req & exec_pend_q;
  assign wr_denied = wr_denied_q;

  // Sticky denied-write flag; a new denial wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_denied_q <= 1'b0;
    end else if (buf_wr_req & ~exec_pend_q) begin
      wr_denied_q <= 1'b1;
    end else if (ctrl_wr & wb_dat_i[3]) begin
      wr_denied_q <= 1'b0;
    end
  end
`else
  assign buf_wr_ok = buf_wr_req;
  assign wr_denied = 1'b0;
`endif

  assign ram_rd_o   = buf_rd;
  assign ram_wr_o   = buf_wr_ok;
  assign ram_wen_o  = buf_wr_ok ? wb_sel_i : 4'd0;
  assign ram_wd_o   = buf_wr_ok ? wb_dat_i : 32'd0;
  assign ram_addr_o = (buf_rd | buf_wr_ok) ? wb_adr_i[RAM_AW+1:2] : '0;

  assign exec_rise  = exec_i & ~exec_q;
  assign abort_rise = abort_i & ~abort_q;

  // Register read mux; CTRL is write-only and unmapped space reads zero.
  always_comb begin
    reg_rdata = 32'd0;
    if (sel_status) begin
      reg_rdata = {28'd0, wr_denied, complete_q, abort_pend_q, exec_pend_q};
    end else if (sel_irqen) begin
      reg_rdata = {30'd0, irq_en_q};
    end
  end

  // Flag next-state: input edges beat CTRL clears, completion clears beat CTRL set.
  always_comb begin
    exec_pend_d  = exec_rise  | (exec_pend_q  & ~(ctrl_wr & wb_dat_i[1]));
    abort_pend_d = abort_rise | (abort_pend_q & ~(ctrl_wr & wb_dat_i[2]));
    if (~exec_i | abort_rise) begin
      complete_d = 1'b0;
    end else begin
      complete_d = complete_q | (ctrl_wr & wb_dat_i[0]);
    end
    irq_en_d = irqen_wr ? wb_dat_i[1:0] : irq_en_q;
    irq_d    = (exec_pend_q & irq_en_q[0]) | (abort_pend_q & irq_en_q[1]);
  end

  // Bus FSM next state plus registered ack/data.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!wb_we_i && sel_buf) begin
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            dat_d   = wb_we_i ? 32'd0 : reg_rdata;
          end
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_ACK;
        ack_d   = wb_cyc_i;
        dat_d   = wb_cyc_i ? ram_rd_i : 32'd0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        dat_d   = 32'd0;
      end
      default: begin
        state_d = ST_IDLE;
        dat_d   = 32'd0;
      end
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  // Control/status registers and input edge-detect history.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      exec_q       <= 1'b0;
      abort_q      <= 1'b0;
      exec_pend_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      complete_q   <= 1'b0;
      irq_en_q     <= {2{IRQ_DEFAULT}};
      irq_q        <= 1'b0;
    end else begin
      exec_q       <= exec_i;
      abort_q      <= abort_i;
      exec_pend_q  <= exec_pend_d;
      abort_pend_q <= abort_pend_d;
      complete_q   <= complete_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign complete_o = complete_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_tpm_bridge.sv
// tb/tb_wb_tpm_bridge.sv - directed self-checking bench for wb_tpm_bridge
`timescale 1ns/1ps
module tb_wb_tpm_bridge;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [16:0] wb_adr = '0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [8:0]  ram_addr_o;
  logic [31:0] ram_wd_o;
  logic [3:0]  ram_wen_o;
  logic        ram_wr_o, ram_rd_o;
  logic [31:0] ram_rd_i;
  logic        exec_i = 1'b0, abort_i = 1'b0;
  logic        complete_o, irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd_data;
  int          lat;
  logic        s_rd, s_wr;
  logic [3:0]  s_wen;
  logic [8:0]  s_addr;
  logic [31:0] s_wd;
  logic        seen_ack;

  logic [31:0] mem [512];

  always #5 clk = ~clk;

  wb_tpm_bridge #(.RAM_AW(9), .IRQ_DEFAULT(1'b0)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .wb_adr_i(wb_adr), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_sel_i(wb_sel), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .ram_addr_o(ram_addr_o), .ram_wd_o(ram_wd_o), .ram_wen_o(ram_wen_o),
    .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_rd_i(ram_rd_i),
    .exec_i(exec_i), .abort_i(abort_i), .complete_o(complete_o), .irq_o(irq_o)
  );

  // Byte-enabled buffer RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wen_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wd_o[b*8 +: 8];
      end
    end
    if (ram_rd_o) ram_rd_i <= mem[ram_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One Wishbone transfer after an idle cycle; records RAM strobes in the request cycle and ack latency.
  task automatic bus(input logic [16:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, input logic set_exec);
    @(posedge clk); #1;
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    if (set_exec) exec_i = 1'b1;
    #1;
    s_rd = ram_rd_o; s_wr = ram_wr_o; s_wen = ram_wen_o; s_addr = ram_addr_o; s_wd = ram_wd_o;
    lat = 0; rd_data = 32'd0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (wb_ack_o) begin
        rd_data = wb_dat_o;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [16:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(adr, 1'b1, dat, sel, 1'b0);
  endtask

  task automatic rd(input logic [16:0] adr);
    bus(adr, 1'b0, 32'd0, 4'hF, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_ram", {ram_rd_o, ram_wr_o, ram_wen_o}, 0);
    check("rst_complete", complete_o, 0);
    check("rst_irq", irq_o, 0);
    nrst = 1'b1;

    rd(17'h01000);
    check("status0_lat", lat, 1);
    check("status0", rd_data, 32'h0);
    rd(17'h01008);
    check("irqen_default", rd_data, 32'h0);

`ifdef TWPM_WB_BUF_PROTECT_EN
    wr(17'h00000, 32'h11111111, 4'hF);
    check("prot_lat", lat, 1);
    check("prot_wr_blocked", s_wr, 0);
    rd(17'h01000);
    check("prot_status_denied", rd_data, 32'h8);
    wr(17'h01004, 32'h8, 4'hF);
    rd(17'h01000);
    check("prot_status_cleared", rd_data, 32'h0);
`else
    wr(17'h00000, 32'h11111111, 4'hF);
    check("noprot_wr", s_wr, 1);
    rd(17'h01000);
    check("noprot_status", rd_data, 32'h0);
    rd(17'h00000);
    check("noprot_readback", rd_data, 32'h11111111);
`endif

    wr(17'h01008, 32'h1, 4'hF);
    rd(17'h01008);
    check("irqen_rw", rd_data, 32'h1);

    // exec rising edge: flag after one edge, irq one edge later
    exec_i = 1'b1;
    @(posedge clk); #1;
    check("irq_lag", irq_o, 0);
    @(posedge clk); #1;
    check("irq_set", irq_o, 1);
    rd(17'h01000);
    check("status_exec", rd_data, 32'h1);

    wr(17'h00004, 32'hDEADBEEF, 4'hF);
    check("w4_lat", lat, 1);
    check("w4_addr", s_addr, 1);
    check("w4_wr", s_wr, 1);
    check("w4_wen", s_wen, 4'hF);
    check("w4_wd", s_wd, 32'hDEADBEEF);
    rd(17'h00004);
    check("r4_rd", s_rd, 1);
    check("r4_addr", s_addr, 1);
    check("r4_lat", lat, 2);
    check("r4_data", rd_data, 32'hDEADBEEF);

    wr(17'h007FC, 32'h0000AB00, 4'h2);
    check("w7fc_wen", s_wen, 4'h2);
    check("w7fc_addr", s_addr, 511);
    check("w7fc_wd", s_wd, 32'h0000AB00);
    rd(17'h007FC);
    check("r7fc_data", rd_data, 32'h0000AB00);
    wr(17'h00004, 32'h000000AA, 4'h1);
    rd(17'h00004);
    check("r4_partial", rd_data, 32'hDEADBEAA);

    wr(17'h01004, 32'h1, 4'hF);
    check("complete_set", complete_o, 1);
    rd(17'h01000);
    check("status_exec_cpl", rd_data, 32'h5);

    exec_i = 1'b0;
    check("complete_hold", complete_o, 1);
    @(posedge clk); #1;
    check("complete_clr_exec", complete_o, 0);
    wr(17'h01004, 32'h2, 4'hF);
    rd(17'h01000);
    check("status_exec_clr", rd_data, 32'h0);
    check("irq_clr", irq_o, 0);

    // clear exec_pend in the same cycle exec_i rises: set wins
    bus(17'h01004, 1'b1, 32'h2, 4'hF, 1'b1);
    rd(17'h01000);
    check("set_beats_clr", rd_data, 32'h1);
    wr(17'h01004, 32'h1, 4'hF);
    check("complete_set2", complete_o, 1);
    abort_i = 1'b1;
    @(posedge clk); #1;
    check("complete_clr_abort", complete_o, 0);
    rd(17'h01000);
    check("status_abort", rd_data, 32'h3);

    rd(17'h1FFFC);
    check("unmapped_lat", lat, 1);
    check("unmapped_data", rd_data, 32'h0);
    rd(17'h01004);
    check("ctrl_reads_zero", rd_data, 32'h0);

    // cyc dropped during RD_WAIT: no ack
    @(posedge clk); #1;
    wb_adr = 17'h00004; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    seen_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_ack = seen_ack | wb_ack_o;
    end
    check("cyc_drop_noack", seen_ack, 0);
    rd(17'h01000);
    check("cyc_drop_status", rd_data, 32'h3);

    // reset asserted during RD_WAIT
    @(posedge clk); #1;
    wb_adr = 17'h00004; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    check("rdwait_noack", wb_ack_o, 0);
    nrst = 1'b0;
    exec_i = 1'b0; abort_i = 1'b0;
    #1;
    check("mid_rst_ack", wb_ack_o, 0);
    check("mid_rst_dat", wb_dat_o, 0);
    check("mid_rst_ram_en", {ram_rd_o, ram_wr_o, ram_wen_o}, 0);
    check("mid_rst_ram_addr", ram_addr_o, 0);
    check("mid_rst_ram_wd", ram_wd_o, 0);
    check("mid_rst_flags", {complete_o, irq_o}, 0);
    seen_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_ack = seen_ack | wb_ack_o;
    end
    check("mid_rst_never_ack", seen_ack, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    rd(17'h01000);
    check("post_rst_status", rd_data, 32'h0);
    rd(17'h01008);
    check("post_rst_irqen", rd_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
